// File: rtl/aes_seq_pkg.sv
// Shared types and widths for the AES data sequencer: FSM state encoding and block/word geometry.
package aes_seq_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_WORD_W  = 32;
    localparam int AES_WORDS   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } aes_seq_state_e;

endpackage

// File: rtl/aes_seq_timer.sv
// Wait-for-result counter: clears on request, counts while enabled, flags the terminal count.
module aes_seq_timer #(
    parameter int unsigned TERMINAL = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [15:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign tc = enable && (count_q == 16'(TERMINAL));

endmodule

// File: rtl/aes_data_sequencer.sv
// Assembles four register-written words into a block, hands it to the AES core and captures the result.
// Optional wait-for-result timeout is enabled by defining AES_SEQ_TIMEOUT_EN.
module aes_data_sequencer
    import aes_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic                   wr_en,
    input  logic [1:0]             wr_addr,
    input  logic [AES_WORD_W-1:0]  wr_data,
    input  logic                   start,
    output logic                   aes_in_valid,
    input  logic                   aes_in_ready,
    output logic [AES_BLOCK_W-1:0] aes_in_data,
    input  logic                   aes_out_valid,
    input  logic [AES_BLOCK_W-1:0] aes_out_data,
    input  logic [1:0]             rd_addr,
    output logic [AES_WORD_W-1:0]  rd_data,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   timeout,
    output aes_seq_state_e         dbg_state
);

    // Handshakes: aes_in_valid/aes_in_ready transfer the block on the edge where both are high;
    // aes_in_valid never drops and aes_in_data never changes before that edge.
    // aes_out_valid is a one-cycle strobe with no back-pressure.

    aes_seq_state_e state_q, state_d;
    logic [AES_WORDS-1:0][AES_WORD_W-1:0] in_words_q;
    logic [AES_BLOCK_W-1:0] result_q;
    logic err_q;
    logic idle_like, accept_start, handshake, capture, err_set;

`ifdef AES_SEQ_TIMEOUT_EN
    logic tc;
    logic timeout_q;

    aes_seq_timer #(
        .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_timer (
        .clk    (ACLK),
        .rst_n  (ARESETN),
        .clear  (handshake),
        .enable (state_q == ST_WAIT),
        .tc     (tc)
    );

    // A result arriving on the terminal-count cycle takes precedence over the timeout.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            timeout_q <= 1'b0;
        end else if (tc && !aes_out_valid) begin
            timeout_q <= 1'b1;
        end else if (accept_start) begin
            timeout_q <= 1'b0;
        end
    end

    assign timeout = timeout_q;
`else
    logic [15:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 16'(TIMEOUT_CYCLES);
    assign timeout = 1'b0;
`endif

    always_comb begin
        idle_like    = (state_q == ST_IDLE) || (state_q == ST_DONE);
        accept_start = idle_like && start;
        handshake    = (state_q == ST_SEND) && aes_in_ready;
        capture      = (state_q == ST_WAIT) && aes_out_valid;
        err_set      = (!idle_like && (wr_en || start)) ||
                       (aes_out_valid && (state_q != ST_WAIT));
        state_d      = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_SEND;
            ST_SEND:          if (aes_in_ready) state_d = ST_WAIT;
            ST_WAIT: begin
                if (aes_out_valid) begin
                    state_d = ST_DONE;
`ifdef AES_SEQ_TIMEOUT_EN
                end else if (tc) begin
                    state_d = ST_IDLE;
`endif
                end
            end
            default:          state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A write landing on the same edge as an accepted start is part of the block being sent.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            in_words_q <= '0;
            result_q   <= '0;
        end else begin
            if (idle_like && wr_en) in_words_q[wr_addr] <= wr_data;
            if (capture)            result_q <= aes_out_data;
        end
    end

    // A new error in the same cycle as an accepted start is kept rather than lost.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (accept_start) begin
            err_q <= 1'b0;
        end
    end

    assign aes_in_valid = (state_q == ST_SEND);
    assign aes_in_data  = in_words_q;
    assign rd_data      = result_q[{rd_addr, 5'd0} +: AES_WORD_W];
    assign busy         = (state_q == ST_SEND) || (state_q == ST_WAIT);
    assign done         = (state_q == ST_DONE);
    assign err          = err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_aes_data_sequencer.sv
// Self-checking bench for aes_data_sequencer; sent blocks are checked through an expected-block queue.
`timescale 1ns/1ps
module tb_aes_data_sequencer;
    import aes_seq_pkg::*;

    localparam int TO_CYC = 8;
`ifdef AES_SEQ_TIMEOUT_EN
    localparam int RESP_DLY = 4;
`else
    localparam int RESP_DLY = 10;
`endif
    localparam logic [127:0] RES_A = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2AA;
    localparam logic [127:0] RES_B = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E155;
    localparam logic [127:0] RES_C = 128'hCAFEF00D_12345678_9ABCDEF0_0BADC0DE;

    logic           ACLK = 1'b0;
    logic           ARESETN;
    logic           wr_en;
    logic [1:0]     wr_addr;
    logic [31:0]    wr_data;
    logic           start;
    logic           aes_in_valid;
    logic           aes_in_ready;
    logic [127:0]   aes_in_data;
    logic           aes_out_valid;
    logic [127:0]   aes_out_data;
    logic [1:0]     rd_addr;
    logic [31:0]    rd_data;
    logic           busy, done, err, timeout;
    aes_seq_state_e dbg_state;

    logic [127:0] exp_q[$];
    logic [31:0]  model [4];
    int total = 0;
    int bad   = 0;

    aes_data_sequencer #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .start         (start),
        .aes_in_valid  (aes_in_valid),
        .aes_in_ready  (aes_in_ready),
        .aes_in_data   (aes_in_data),
        .aes_out_valid (aes_out_valid),
        .aes_out_data  (aes_out_data),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .timeout       (timeout),
        .dbg_state     (dbg_state)
    );

    always #5 ACLK = ~ACLK;

    // Scoreboard: every block transfer is compared against the oldest expected block.
    always @(negedge ACLK) begin
        logic [127:0] exp_blk;
        if (ARESETN && aes_in_valid && aes_in_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL in_block: unexpected transfer got=%h want=none", aes_in_data);
            end else begin
                exp_blk = exp_q.pop_front();
                if (aes_in_data !== exp_blk) begin
                    bad++;
                    $display("FAIL in_block: got=%h want=%h", aes_in_data, exp_blk);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] model_block();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_write(input logic [1:0] k, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = k; wr_data = d; model[k] = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        exp_q.push_back(model_block());
        tick();
        start = 1'b0;
    endtask

    task automatic respond(input logic [127:0] res);
        aes_out_valid = 1'b1; aes_out_data = res;
        tick();
        aes_out_valid = 1'b0; aes_out_data = {4{$urandom()}};
    endtask

    task automatic wait_state(input aes_seq_state_e st, input int max_cyc, input string name);
        int n = 0;
        while (dbg_state != st && n < max_cyc) begin
            tick();
            n++;
        end
        total++;
        if (dbg_state != st) begin
            bad++;
            $display("FAIL %s: state got=%0d want=%0d after %0d cycles", name, dbg_state, st, n);
        end
    endtask

    task automatic test_reset();
        ARESETN = 1'b0; wr_en = 0; wr_addr = 0; wr_data = 0; start = 0;
        aes_in_ready = 0; aes_out_valid = 0; aes_out_data = 0; rd_addr = 0;
        for (int k = 0; k < 4; k++) model[k] = 32'h0;
        #3;
        total++;
        if ({aes_in_valid, busy, done, err, timeout} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got=%b want=00000", {aes_in_valid, busy, done, err, timeout});
        end
        total++;
        if (aes_in_data !== 128'h0) begin
            bad++; $display("FAIL reset_in_data: got=%h want=0", aes_in_data);
        end
        total++;
        if (dbg_state !== ST_IDLE) begin
            bad++; $display("FAIL reset_state: got=%0d want=%0d", dbg_state, ST_IDLE);
        end
        for (int k = 0; k < 4; k++) begin
            rd_addr = 2'(k); #1;
            total++;
            if (rd_data !== 32'h0) begin
                bad++; $display("FAIL reset_rd%0d: got=%h want=0", k, rd_data);
            end
        end
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        tick();
    endtask

    task automatic test_normal();
        aes_in_ready = 1'b1;
        for (int k = 0; k < 4; k++) do_write(2'(k), 32'(k + 1));
        do_start();
        total++;
        if (aes_in_valid !== 1'b1 || aes_in_data !== 128'h00000004_00000003_00000002_00000001) begin
            bad++;
            $display("FAIL normal_send: valid=%b data=%h want valid=1 data=00000004000000030000000200000001",
                     aes_in_valid, aes_in_data);
        end
        wait_state(ST_WAIT, 5, "normal_wait");
        repeat (RESP_DLY - 1) tick();
        respond(RES_A);
        total++;
        if ({done, busy, err} !== 3'b100) begin
            bad++; $display("FAIL normal_done: done,busy,err got=%b want=100", {done, busy, err});
        end
        for (int k = 0; k < 4; k++) begin
            rd_addr = 2'(k); #1;
            total++;
            if (rd_data !== RES_A[k*32 +: 32]) begin
                bad++; $display("FAIL normal_rd%0d: got=%h want=%h", k, rd_data, RES_A[k*32 +: 32]);
            end
        end
    endtask

    task automatic test_backpressure();
        aes_in_ready = 1'b0;
        do_start();
        for (int c = 0; c < 5; c++) begin
            total++;
            if (aes_in_valid !== 1'b1 || busy !== 1'b1 || aes_in_data !== model_block()) begin
                bad++;
                $display("FAIL backpressure_c%0d: valid=%b busy=%b data=%h want 1 1 %h",
                         c, aes_in_valid, busy, aes_in_data, model_block());
            end
            tick();
        end
        aes_in_ready = 1'b1;
        wait_state(ST_WAIT, 3, "backpressure_wait");
        respond(RES_B);
        total++;
        if (done !== 1'b1) begin
            bad++; $display("FAIL backpressure_done: got=%b want=1", done);
        end
    endtask

    task automatic test_write_busy();
        do_start();
        wait_state(ST_WAIT, 5, "wrbusy_wait");
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 1'b0;
        total++;
        if (err !== 1'b1) begin
            bad++; $display("FAIL wrbusy_err: got=%b want=1", err);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (dbg_state !== ST_WAIT) begin
            bad++; $display("FAIL wrbusy_start_ignored: state got=%0d want=%0d", dbg_state, ST_WAIT);
        end
        respond(RES_C);
        total++;
        if (err !== 1'b1 || done !== 1'b1) begin
            bad++; $display("FAIL wrbusy_sticky: err=%b done=%b want 1 1", err, done);
        end
        do_start();
        total++;
        if (err !== 1'b0 || aes_in_data[95:64] !== 32'h00000003) begin
            bad++;
            $display("FAIL wrbusy_next: err=%b word2=%h want 0 00000003", err, aes_in_data[95:64]);
        end
        wait_state(ST_WAIT, 5, "wrbusy_wait2");
        respond(RES_A);
    endtask

    task automatic test_stray_out_valid();
        respond(RES_C);
        total++;
        if (err !== 1'b1 || dbg_state !== ST_DONE) begin
            bad++; $display("FAIL stray_ov: err=%b state=%0d want 1 %0d", err, dbg_state, ST_DONE);
        end
        rd_addr = 2'd0; #1;
        total++;
        if (rd_data !== RES_A[31:0]) begin
            bad++; $display("FAIL stray_ov_rd: got=%h want=%h", rd_data, RES_A[31:0]);
        end
    endtask

`ifdef AES_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        do_start();
        wait_state(ST_WAIT, 5, "timeout_wait");
        while (dbg_state == ST_WAIT && n < 50) begin
            n++;
            tick();
        end
        total++;
        if (n !== TO_CYC || timeout !== 1'b1 || dbg_state !== ST_IDLE) begin
            bad++;
            $display("FAIL timeout_exit: wait_cycles=%0d timeout=%b state=%0d want %0d 1 %0d",
                     n, timeout, dbg_state, TO_CYC, ST_IDLE);
        end
        for (int k = 0; k < 4; k++) begin
            rd_addr = 2'(k); #1;
            total++;
            if (rd_data !== RES_A[k*32 +: 32]) begin
                bad++; $display("FAIL timeout_rd%0d: got=%h want=%h", k, rd_data, RES_A[k*32 +: 32]);
            end
        end
        do_start();
        total++;
        if (timeout !== 1'b0) begin
            bad++; $display("FAIL timeout_clear: got=%b want=0", timeout);
        end
        wait_state(ST_WAIT, 5, "race_wait");
        repeat (TO_CYC - 1) tick();
        respond(RES_B);
        total++;
        if (dbg_state !== ST_DONE || timeout !== 1'b0) begin
            bad++; $display("FAIL race: state=%0d timeout=%b want %0d 0", dbg_state, timeout, ST_DONE);
        end
        rd_addr = 2'd0; #1;
        total++;
        if (rd_data !== RES_B[31:0]) begin
            bad++; $display("FAIL race_rd: got=%h want=%h", rd_data, RES_B[31:0]);
        end
    endtask
`else
    task automatic test_no_timeout();
        do_start();
        wait_state(ST_WAIT, 5, "notimeout_wait");
        repeat (40) tick();
        total++;
        if (dbg_state !== ST_WAIT || busy !== 1'b1 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL notimeout_hold: state=%0d busy=%b timeout=%b want %0d 1 0",
                     dbg_state, busy, timeout, ST_WAIT);
        end
        respond(RES_B);
        total++;
        if (done !== 1'b1) begin
            bad++; $display("FAIL notimeout_done: got=%b want=1", done);
        end
    endtask
`endif

    task automatic test_reset_mid();
        do_start();
        wait_state(ST_WAIT, 5, "rstmid_wait");
        #2 ARESETN = 1'b0;
        for (int k = 0; k < 4; k++) model[k] = 32'h0;
        #1;
        total++;
        if ({aes_in_valid, busy, done, err, timeout} !== 5'b0 || aes_in_data !== 128'h0 ||
            dbg_state !== ST_IDLE) begin
            bad++;
            $display("FAIL rstmid_outputs: flags=%b data=%h state=%0d want 0 0 %0d",
                     {aes_in_valid, busy, done, err, timeout}, aes_in_data, dbg_state, ST_IDLE);
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        tick();
        respond(RES_C);
        total++;
        if (err !== 1'b1 || done !== 1'b0 || dbg_state !== ST_IDLE) begin
            bad++;
            $display("FAIL rstmid_late_ov: err=%b done=%b state=%0d want 1 0 %0d",
                     err, done, dbg_state, ST_IDLE);
        end
        for (int k = 0; k < 4; k++) begin
            rd_addr = 2'(k); #1;
            total++;
            if (rd_data !== 32'h0) begin
                bad++; $display("FAIL rstmid_rd%0d: got=%h want=0", k, rd_data);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) do_write(2'(k), $urandom_range(32'hFFFF, 32'h100));
        do_start();
        wait_state(ST_WAIT, 5, "b2b_wait");
        respond(RES_A);
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'h11111111; model[0] = 32'h11111111;
        start = 1'b1;
        exp_q.push_back(model_block());
        tick();
        wr_en = 1'b0; start = 1'b0;
        total++;
        if (done !== 1'b0 || aes_in_valid !== 1'b1 || aes_in_data[31:0] !== 32'h11111111) begin
            bad++;
            $display("FAIL b2b_send: done=%b valid=%b word0=%h want 0 1 11111111",
                     done, aes_in_valid, aes_in_data[31:0]);
        end
        wait_state(ST_WAIT, 5, "b2b_wait2");
        respond(RES_B);
        total++;
        if (done !== 1'b1 || err !== 1'b0) begin
            bad++; $display("FAIL b2b_done: done=%b err=%b want 1 0", done, err);
        end
        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL drain: pending=%0d want=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_backpressure();
        test_write_busy();
        test_stray_out_valid();
`ifdef AES_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
